floating_alu: RTL and testbench

Multi-cycle IEEE-754 single-precision adder/subtractor with a start/done handshake. Operands are latched on start. An internal FSM then aligns, adds/subtracts, normalizes and rounds, and presents the result on out with a one-cycle done pulse. It sits as a standalone arithmetic unit driven by a controller.

---
 rtl/floating_alu_pkg.sv | 33 +++
 rtl/floating_alu_lzc.sv | 14 +
 rtl/floating_alu.sv | 176 +++++++++++++++++
 tb/tb_floating_alu.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/floating_alu_pkg.sv
// Shared types and constants for the single-precision add/sub unit.
// Imported by the top and its datapath helpers.
package floating_alu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ALIGN,
        ADDSUB,
        NORM,
        ROUND,
        DONE
    } state_t;

    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;
    localparam int BIAS   = 127;

    localparam logic [31:0] QNAN    = 32'h7FC00000;
    localparam logic [31:0] POS_INF = 32'h7F800000;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;

    // Aligned operands handed from ALIGN to ADDSUB.
    typedef struct packed {
        logic        sign;
        logic        effsub;
        logic [9:0]  exp;
        logic [26:0] big;
        logic [26:0] sml;
    } align_t;

endpackage

// File: rtl/floating_alu_lzc.sv
// 27-bit leading-zero counter; an all-zero input yields 27.
// Single-cycle priority encoder used by normalization.
module fp_lzc (
    input  logic [26:0] val,
    output logic [4:0]  cnt
);

    always_comb begin
        cnt = 5'd27;
        for (int i = 0; i < 27; i++)
            if (val[i]) cnt = 5'(26 - i);
    end

endmodule

// File: rtl/floating_alu.sv
// Multi-cycle IEEE-754 single add/sub with start/done handshake.
// Flush-to-zero inputs, round to nearest even.
module floating_alu
    import floating_alu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] inp1,
    input  logic [31:0] inp2,
    input  logic [2:0]  opt,
    output logic [31:0] out,
    output logic        done
);

    state_t state, next;

    logic [31:0] a_q, b_q;
    logic        sub_q;
    logic        spec_q;
    logic [31:0] sval_q;
    align_t      al_q;
    logic [27:0] sum_q;
    logic [26:0] nrm_q;
    logic        zero_q;
    logic signed [9:0] e_q;
    logic [31:0] res_q;

    logic unused_opt;
    assign unused_opt = ^opt[2:1];

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next;
    end

    always_comb begin
        next = state;
        unique case (state)
            IDLE:    if (start) next = ALIGN;
            ALIGN:   next = ADDSUB;
            ADDSUB:  next = NORM;
            NORM:    next = ROUND;
            ROUND:   next = DONE;
            DONE:    next = IDLE;
            default: next = IDLE;
        endcase
    end

    // Unpack with flush-to-zero: exponent 0 drops the hidden bit.
    logic        sa, sb;
    logic [7:0]  ea, eb, eh, el, diff;
    logic [23:0] ma, mb, mh, ml;
    logic        nan_a, nan_b, inf_a, inf_b, a_ge;
    logic [50:0] ext;
    logic [26:0] sml;
    logic        spec;
    logic [31:0] sval;

    assign sa    = a_q[31];
    assign sb    = b_q[31] ^ sub_q;
    assign ea    = a_q[30:23];
    assign eb    = b_q[30:23];
    assign ma    = (ea == 8'd0) ? 24'd0 : {1'b1, a_q[22:0]};
    assign mb    = (eb == 8'd0) ? 24'd0 : {1'b1, b_q[22:0]};
    assign nan_a = (ea == 8'hFF) && (a_q[22:0] != 23'd0);
    assign nan_b = (eb == 8'hFF) && (b_q[22:0] != 23'd0);
    assign inf_a = (ea == 8'hFF) && (a_q[22:0] == 23'd0);
    assign inf_b = (eb == 8'hFF) && (b_q[22:0] == 23'd0);
    assign a_ge  = {ea, ma} >= {eb, mb};
    assign eh    = a_ge ? ea : eb;
    assign el    = a_ge ? eb : ea;
    assign mh    = a_ge ? ma : mb;
    assign ml    = a_ge ? mb : ma;
    assign diff  = eh - el;
    assign ext   = {ml, 27'd0} >> diff;
    assign sml   = (diff >= 8'd26) ? {26'd0, |ml}
                                   : {ext[50:25], |ext[24:0]};

    always_comb begin
        spec = 1'b1;
        sval = QNAN;
        if (nan_a || nan_b)
            sval = QNAN;
        else if (inf_a && inf_b)
            sval = (sa == sb) ? {sa, POS_INF[30:0]} : QNAN;
        else if (inf_a)
            sval = {sa, POS_INF[30:0]};
        else if (inf_b)
            sval = {sb, POS_INF[30:0]};
        else if (ea == 8'd0 && eb == 8'd0)
            sval = {sa & sb, 31'd0};
        else
            spec = 1'b0;
    end

    logic [4:0] lz;

    fp_lzc u_lzc (
        .val (sum_q[26:0]),
        .cnt (lz)
    );

    // Round to nearest even on guard/round/sticky.
    logic [23:0] m;
    logic        inc;
    logic [24:0] m25;
    logic [22:0] mf;
    logic signed [9:0] er;
    logic [31:0] rres;

    assign m   = nrm_q[26:3];
    assign inc = nrm_q[2] & (nrm_q[1] | nrm_q[0] | m[0]);
    assign m25 = {1'b0, m} + {24'd0, inc};
    assign mf  = m25[24] ? m25[23:1] : m25[22:0];
    assign er  = m25[24] ? e_q + 10'sd1 : e_q;

    always_comb begin
        if (spec_q)
            rres = sval_q;
        else if (zero_q)
            rres = 32'h0;
        else if (er >= 10'sd255)
            rres = {al_q.sign, POS_INF[30:0]};
        else if (er < 10'sd1)
            rres = {al_q.sign, 31'd0};
        else
            rres = {al_q.sign, er[7:0], mf};
    end

    always_ff @(posedge clk) begin
        unique case (state)
            IDLE: if (start) begin
                a_q   <= inp1;
                b_q   <= inp2;
                sub_q <= (opt[0] == OP_SUB[0]);
            end
            ALIGN: begin
                spec_q      <= spec;
                sval_q      <= sval;
                al_q.sign   <= a_ge ? sa : sb;
                al_q.effsub <= sa ^ sb;
                al_q.exp    <= {2'b00, eh};
                al_q.big    <= {mh, 3'b000};
                al_q.sml    <= sml;
            end
            ADDSUB:
                sum_q <= al_q.effsub ? {1'b0, al_q.big} - {1'b0, al_q.sml}
                                     : {1'b0, al_q.big} + {1'b0, al_q.sml};
            NORM: begin
                if (sum_q[27]) begin
                    nrm_q  <= {sum_q[27:2], sum_q[1] | sum_q[0]};
                    e_q    <= $signed(al_q.exp) + 10'sd1;
                    zero_q <= 1'b0;
                end else begin
                    nrm_q  <= sum_q[26:0] << lz;
                    e_q    <= $signed(al_q.exp) - $signed({5'd0, lz});
                    zero_q <= (sum_q == 28'd0);
                end
            end
            ROUND:   res_q <= rres;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out  <= 32'h0;
            done <= 1'b0;
        end else begin
            done <= (state == DONE);
            if (state == DONE) out <= res_q;
        end
    end

endmodule

// File: tb/tb_floating_alu.sv
// Scoreboard bench for floating_alu: queued expectations
// are popped when done pulses.
module tb_floating_alu;
    import floating_alu_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] inp1 = '0;
    logic [31:0] inp2 = '0;
    logic [2:0]  opt = '0;
    logic [31:0] out;
    logic        done;

    int errors = 0;
    int checks = 0;

    logic [31:0] expq[$];
    string       tagq[$];

    floating_alu dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .inp1  (inp1),
        .inp2  (inp2),
        .opt   (opt),
        .out   (out),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (done === 1'b1) begin
            if (expq.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
            else chk(tagq.pop_front(), out, expq.pop_front());
        end
    end

    task automatic run(input string tag, input logic [31:0] a,
                       input logic [31:0] b, input logic [2:0] op,
                       input logic [31:0] exp, input bit scramble);
        int n;
        @(negedge clk);
        inp1 = a;
        inp2 = b;
        opt = op;
        start = 1'b1;
        expq.push_back(exp);
        tagq.push_back(tag);
        @(negedge clk);
        start = 1'b0;
        if (scramble) begin
            inp1 = $urandom;
            inp2 = $urandom;
            opt = ~op;
        end
        n = 1;
        while (done !== 1'b1 && n < 20) begin
            @(posedge clk);
            #1;
            if (done !== 1'b1) n++;
        end
        chk({tag, "_lat"}, 32'(n), 32'd5);
        @(posedge clk);
        #1;
        chk({tag, "_pulse"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int cyc;
        int nd;
        int t[3];

        @(posedge clk);
        #1;
        chk("rst_out", out, 32'h0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_state", {29'd0, dut.state}, {29'd0, IDLE});
        @(negedge clk);
        reset = 1'b0;

        // abort during ADDSUB
        inp1 = 32'h3F800000;
        inp2 = 32'h3F800000;
        opt = 3'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("abort_in_addsub", {29'd0, dut.state}, {29'd0, ADDSUB});
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_state", {29'd0, dut.state}, {29'd0, IDLE});
        chk("abort_out", out, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        nd = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) nd++;
        end
        chk("abort_nodone", 32'(nd), 32'd0);
        chk("abort_out_hold", out, 32'h0);

        run("add_tie", 32'h40080EBF, 32'h40AD999A, 3'd0, 32'h40F1A0FA, 0);
        run("sub_exact", 32'h40080EBF, 32'h40AD999A, 3'd1, 32'hC0532475, 1);
        run("cancel", 32'h3F800000, 32'h3F800000, OP_SUB, 32'h00000000, 0);
        run("ovf", 32'h7F7FFFFF, 32'h7F7FFFFF, OP_ADD, 32'h7F800000, 0);
        run("nan", 32'h7FC00000, 32'h3F800000, OP_ADD, 32'h7FC00000, 0);
        run("inf_inf", 32'h7F800000, 32'h7F800000, OP_SUB, 32'h7FC00000, 0);
        run("denorm", 32'h3F800000, 32'h00000001, OP_ADD, 32'h3F800000, 0);
        run("tie_even", 32'h3F800000, 32'h33800000, OP_ADD, 32'h3F800000, 0);
        run("tie_odd", 32'h3F800001, 32'h33800000, OP_ADD, 32'h3F800002, 0);
        run("opt_hi_add", 32'h40000000, 32'h3F800000, 3'b110, 32'h40400000, 0);
        run("opt_hi_sub", 32'h3F800000, 32'h40000000, 3'b011, 32'hBF800000, 0);
        run("neg_inf", 32'h3F800000, 32'h7F800000, OP_SUB, 32'hFF800000, 0);

        // back-to-back with start held high
        @(negedge clk);
        inp1 = 32'h3F800000;
        inp2 = 32'h3F800000;
        opt = OP_ADD;
        start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            expq.push_back(32'h40000000);
            tagq.push_back("held");
        end
        nd = 0;
        cyc = 0;
        while (nd < 3 && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
            if (done === 1'b1) begin
                t[nd] = cyc;
                nd++;
            end
        end
        @(negedge clk);
        start = 1'b0;
        chk("held_count", 32'(nd), 32'd3);
        chk("held_first", 32'(t[0]), 32'd6);
        chk("held_period1", 32'(t[1] - t[0]), 32'd6);
        chk("held_period2", 32'(t[2] - t[1]), 32'd6);
        repeat (10) @(posedge clk);
        #1;
        chk("queue_empty", 32'(expq.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
